// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and the latched access op.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single mem_cntrl request port between NUM_PORTS requesters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  input  logic [NUM_PORTS-1:0]            port_r_en,
  input  logic [NUM_PORTS-1:0]            port_w_en,
  output logic [NUM_PORTS-1:0]            port_cplt,
  output logic [NUM_PORTS-1:0]            port_err,
  output logic [DATA_WIDTH-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]            grant,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_data_in,
  output logic                            mem_r_en,
  output logic                            mem_w_en,
  input  logic                            mem_rdy,
  input  logic                            mem_cplt,
  input  logic [DATA_WIDTH-1:0]           mem_data_out
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PORTS - 1);

  arb_state_t            state_q, state_d;
  mem_op_t               op_q, op_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d;
  logic [NUM_PORTS-1:0]  cplt_q, cplt_d;
  logic [NUM_PORTS-1:0]  err_q, err_d;

  logic [NUM_PORTS-1:0]  req_s, pick_gnt_s;
  logic [IW-1:0]         pick_idx_s;
  logic                  done_s, r_strobe_s, w_strobe_s;

  assign req_s = port_r_en | port_w_en;

  rr_picker #(.N(NUM_PORTS)) u_picker (
    .req (req_s),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    grant_d    = grant_q;
    cplt_d     = '0;
    err_d      = '0;
    done_s     = 1'b0;
    r_strobe_s = 1'b0;
    w_strobe_s = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|req_s) begin
          idx_d   = pick_idx_s;
          addr_d  = port_addr[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = port_wdata[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          op_d    = port_r_en[pick_idx_s] ? OP_READ : OP_WRITE;
          grant_d = pick_gnt_s;
          state_d = ARB_ISSUE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        // Strobe is combinational on mem_rdy so it lands in the first ready cycle.
        if (mem_rdy) begin
          r_strobe_s = (op_q == OP_READ);
          w_strobe_s = (op_q == OP_WRITE);
          cnt_d      = '0;
          state_d    = ARB_WAIT;
        end else begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_cplt) begin
          rdata_d = (op_q == OP_READ) ? mem_data_out : rdata_q;
          cplt_d  = grant_q;
          done_s  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cplt_d = grant_q;
          err_d  = grant_q;
          done_s = 1'b1;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
    if (done_s) begin
      rr_ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      grant_d  = '0;
      state_d  = ARB_IDLE;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      op_q     <= OP_READ;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      grant_q  <= '0;
      cplt_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      grant_q  <= grant_d;
      cplt_q   <= cplt_d;
      err_q    <= err_d;
    end
  end

  assign port_cplt   = cplt_q;
  assign port_err    = err_q;
  assign port_rdata  = rdata_q;
  assign grant       = grant_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_r_en    = r_strobe_s;
  assign mem_w_en    = w_strobe_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two ports, TIMEOUT=16, hand-computed expectations.
module tb_mem_arbiter;

  localparam int NP = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata;
  logic [NP-1:0]    port_r_en, port_w_en;
  logic [NP-1:0]    port_cplt, port_err, grant;
  logic [DW-1:0]    port_rdata;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_data_in, mem_data_out;
  logic             mem_r_en, mem_w_en, mem_rdy, mem_cplt;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .port_addr    (port_addr),
    .port_wdata   (port_wdata),
    .port_r_en    (port_r_en),
    .port_w_en    (port_w_en),
    .port_cplt    (port_cplt),
    .port_err     (port_err),
    .port_rdata   (port_rdata),
    .grant        (grant),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .mem_rdy      (mem_rdy),
    .mem_cplt     (mem_cplt),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_r_en || mem_w_en) n_strobe <= n_strobe + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of cycles until a strobe is visible (50 = never).
  task automatic wait_strobe(output int n);
    n = 0;
    while (!(mem_r_en || mem_w_en) && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic mem_done(input logic [DW-1:0] data);
    mem_cplt     = 1'b1;
    mem_data_out = data;
    tick();
    mem_cplt     = 1'b0;
  endtask

  initial begin
    int s0, n, bad;
    logic [NP-1:0] exp_g;
    logic [AW-1:0] exp_a;

    rst = 1'b1; port_addr = '0; port_wdata = '0; port_r_en = '0; port_w_en = '0;
    mem_rdy = 1'b0; mem_cplt = 1'b0; mem_data_out = '0;
    repeat (2) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_cplt", 32'(port_cplt), 32'h0);
    check("rst_err", 32'(port_err), 32'h0);
    check("rst_rdata", 32'(port_rdata), 32'h0);
    check("rst_strobes", {30'h0, mem_r_en, mem_w_en}, 32'h0);
    check("rst_addr_data", {mem_addr, mem_data_in}, 32'h0);
    rst = 1'b0;
    tick();

    // Single read on port0
    s0 = n_strobe;
    port_addr[15:0] = 16'h0010; port_r_en = 2'b01; mem_rdy = 1'b1;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_r_en", 32'(mem_r_en), 32'h1);
    check("t1_addr", 32'(mem_addr), 32'h0010);
    tick();
    check("t1_r_en_drop", 32'(mem_r_en), 32'h0);
    repeat (4) tick();
    mem_done(16'hBEEF);
    check("t1_cplt", 32'(port_cplt), 32'h1);
    check("t1_rdata", 32'(port_rdata), 32'hBEEF);
    check("t1_no_err", 32'(port_err), 32'h0);
    check("t1_grant_clr", 32'(grant), 32'h0);
    check("t1_one_strobe", 32'(n_strobe - s0), 32'h1);
    port_r_en = 2'b00;
    tick();
    check("t1_cplt_pulse", 32'(port_cplt), 32'h0);

    // Contention from reset: 0, 1, 0 with both requests held
    rst = 1'b1;
    tick();
    port_addr = {16'h0222, 16'h0010}; port_r_en = 2'b11;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 16'h0010 : 16'h0222;
      wait_strobe(n);
      check("t2_strobe_lat", 32'(n), 32'h1);
      check("t2_grant", 32'(grant), 32'(exp_g));
      check("t2_addr", 32'(mem_addr), 32'(exp_a));
      tick();
      mem_done(16'h1000 + 16'(i));
      check("t2_cplt", 32'(port_cplt), 32'(exp_g));
      if (i == 2) port_r_en = 2'b00;
    end

    // mem_rdy stalls ISSUE for 20 cycles (rr_ptr now 1)
    port_addr[31:16] = 16'h0333; port_r_en = 2'b10; mem_rdy = 1'b0;
    tick();
    check("t3_grant", 32'(grant), 32'h2);
    check("t3_no_strobe", 32'(mem_r_en), 32'h0);
    bad = 0;
    repeat (20) begin
      tick();
      if (mem_r_en || mem_w_en || mem_addr != 16'h0333 || grant != 2'b10) bad++;
    end
    check("t3_stall_stable", 32'(bad), 32'h0);
    mem_rdy = 1'b1;
    #1;
    check("t3_strobe_on_rdy", 32'(mem_r_en), 32'h1);
    tick();
    mem_done(16'h5A5A);
    check("t3_cplt", 32'(port_cplt), 32'h2);
    check("t3_rdata", 32'(port_rdata), 32'h5A5A);
    port_r_en = 2'b00;

    // IO write on port1; requester drops w_en right after the grant
    port_addr[31:16] = 16'h0100; port_wdata[31:16] = 16'h1234; port_w_en = 2'b10;
    tick();
    check("t4_w_en", 32'(mem_w_en), 32'h1);
    check("t4_r_en", 32'(mem_r_en), 32'h0);
    check("t4_addr", 32'(mem_addr), 32'h0100);
    check("t4_wdata", 32'(mem_data_in), 32'h1234);
    port_w_en = 2'b00;
    bad = 0;
    repeat (3) begin
      tick();
      if (mem_data_in != 16'h1234 || mem_addr != 16'h0100 || grant != 2'b10 || mem_w_en) bad++;
    end
    check("t4_hold", 32'(bad), 32'h0);
    mem_done(16'hDEAD);
    check("t4_cplt", 32'(port_cplt), 32'h2);
    check("t4_rdata_kept", 32'(port_rdata), 32'h5A5A);

    // Timeout: 16 WAIT cycles then the registered completion
    port_r_en = 2'b01;
    tick();
    check("t5_r_en", 32'(mem_r_en), 32'h1);
    n = 0;
    while (port_cplt == 2'b00 && n < 40) begin
      tick();
      n++;
    end
    check("t5_latency", 32'(n), 32'd17);
    check("t5_cplt", 32'(port_cplt), 32'h1);
    check("t5_err", 32'(port_err), 32'h1);
    check("t5_grant_clr", 32'(grant), 32'h0);
    port_r_en = 2'b00;
    tick();
    check("t5_err_pulse", 32'(port_err), 32'h0);

    // Reset while in WAIT (rr_ptr now 1)
    port_addr[31:16] = 16'h0333; port_r_en = 2'b10;
    tick();
    tick();
    check("t6_grant_wait", 32'(grant), 32'h2);
    rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_addr", 32'(mem_addr), 32'h0);
    port_r_en = 2'b00;
    tick();
    rst = 1'b0;
    mem_cplt = 1'b1; mem_data_out = 16'hFFFF;
    bad = 0;
    repeat (3) begin
      tick();
      mem_cplt = 1'b0;
      if (port_cplt != 2'b00 || grant != 2'b00 || port_rdata != 16'h0) bad++;
    end
    check("t6_stray_cplt", 32'(bad), 32'h0);
    port_r_en = 2'b10;
    tick();
    check("t6_regrant", 32'(grant), 32'h2);
    check("t6_strobe", 32'(mem_r_en), 32'h1);
    tick();
    mem_done(16'h7777);
    check("t6_cplt", 32'(port_cplt), 32'h2);
    check("t6_rdata", 32'(port_rdata), 32'h7777);
    port_r_en = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
